bv_match_sched: RTL and testbench

- Sequencer for the bit-vector match datapath. It accepts one rule-match bit vector and walks it LSB-first, skipping all-zero chunks of CHUNK bits per cycle, the same skip-and-count step the bv_count stages perform.
- For every set bit it emits one rule index on a valid/ready output, flagging the final index. An all-zero vector produces a single miss beat.
- Sits between the final bv AND stage and the action-table lookup.

---
 rtl/bv_match_sched_if.sv | 26 ++
 rtl/bv_match_sched.sv | 110 +++++++++++
 tb/tb_bv_match_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bv_match_sched_if.sv
// Vector-in / match-beat-out handshake bundle for bv_match_sched.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface bv_match_sched_if #(
  parameter int WIDTH       = 64,
  parameter int WIDTH_COUNT = 6
);
  logic                   bv_valid;
  logic                   bv_ready;
  logic [WIDTH-1:0]       bv;
  logic                   match_valid;
  logic                   match_ready;
  logic [WIDTH_COUNT-1:0] match_index;
  logic                   match_hit;
  logic                   match_last;
  logic [WIDTH_COUNT:0]   match_num;

  modport slave (
    input  bv_valid, bv, match_ready,
    output bv_ready, match_valid, match_index, match_hit, match_last, match_num
  );

  modport master (
    output bv_valid, bv, match_ready,
    input  bv_ready, match_valid, match_index, match_hit, match_last, match_num
  );
endinterface

// File: rtl/bv_match_sched.sv
// Walks a rule-match bit vector LSB-first, skipping empty CHUNK-bit groups,
// and emits one rule index per set bit (or a single miss beat for an empty vector).
//
// state | meaning
// IDLE  | waiting for a vector, bv_ready=1
// SCAN  | one skip-or-pick decision per cycle on the low chunk of r_vec
// EMIT  | beat presented, held until match_ready
module bv_match_sched #(
  parameter int WIDTH       = 64,
  parameter int WIDTH_COUNT = 6,
  parameter int CHUNK       = 8
) (
  input logic              clk,
  input logic              reset,
  bv_match_sched_if.slave  bus
);
  localparam int P_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [WIDTH-1:0]       r_vec, w_vec_nxt;
  logic [WIDTH_COUNT-1:0] r_base, w_base_nxt;
  logic [WIDTH_COUNT-1:0] r_index, w_index_nxt;
  logic                   r_hit, w_hit_nxt;
  logic                   r_last, w_last_nxt;
  logic [WIDTH_COUNT:0]   r_num, w_num_nxt;

  logic [P_W-1:0]         w_p;
  logic [WIDTH-1:0]       w_vec_clr;

  // Lowest set bit of the current chunk; scanned downward so the LSB wins.
  always_comb begin
    w_p = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (r_vec[i]) w_p = P_W'(i);
    end
    w_vec_clr = r_vec & ~(WIDTH'(1) << w_p);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_base  <= '0;
      r_index <= '0;
      r_hit   <= 1'b0;
      r_last  <= 1'b0;
      r_num   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_base  <= w_base_nxt;
      r_index <= w_index_nxt;
      r_hit   <= w_hit_nxt;
      r_last  <= w_last_nxt;
      r_num   <= w_num_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_base_nxt  = r_base;
    w_index_nxt = r_index;
    w_hit_nxt   = r_hit;
    w_last_nxt  = r_last;
    w_num_nxt   = r_num;
    case (r_state)
      S_IDLE: begin
        if (bus.bv_valid) begin
          w_vec_nxt   = bus.bv;
          w_base_nxt  = '0;
          w_num_nxt   = '0;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_vec == '0) begin
          // Only reachable for an all-zero input: a single miss beat.
          w_index_nxt = '0;
          w_hit_nxt   = 1'b0;
          w_last_nxt  = 1'b1;
          w_state_nxt = S_EMIT;
        end else if (r_vec[CHUNK-1:0] == '0) begin
          w_vec_nxt  = r_vec >> CHUNK;
          w_base_nxt = r_base + WIDTH_COUNT'(CHUNK);
        end else begin
          w_index_nxt = r_base + WIDTH_COUNT'(w_p);
          w_hit_nxt   = 1'b1;
          w_num_nxt   = r_num + (WIDTH_COUNT+1)'(1);
          w_last_nxt  = (w_vec_clr == '0);
          w_vec_nxt   = w_vec_clr;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.match_ready) w_state_nxt = r_last ? S_IDLE : S_SCAN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.bv_ready    = (r_state == S_IDLE);
  assign bus.match_valid = (r_state == S_EMIT);
  assign bus.match_index = r_index;
  assign bus.match_hit   = r_hit;
  assign bus.match_last  = r_last;
  assign bus.match_num   = r_num;
endmodule

// File: tb/tb_bv_match_sched.sv
// Self-checking bench for bv_match_sched: directed scenarios plus randomized
// vectors compared against a bit-list / chunk-distance timing model.
module tb_bv_match_sched;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t_acc = 0;

  bv_match_sched_if #(.WIDTH(64), .WIDTH_COUNT(6)) bus ();

  bv_match_sched #(.WIDTH(64), .WIDTH_COUNT(6), .CHUNK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int   cap_idx[$];
  bit   cap_hit[$];
  bit   cap_last[$];
  int   cap_num[$];
  int   cap_cyc[$];
  bit   cap_timeout;
  logic cap_rdy_after;

  task automatic send_vec(input logic [63:0] v);
    bus.bv       = v;
    bus.bv_valid = 1'b1;
    @(posedge clk);
    #1;
    t_acc        = cyc;
    bus.bv_valid = 1'b0;
    bus.bv       = '0;
  endtask

  // Records every beat (relative to the accept edge) until a last beat or timeout.
  task automatic collect();
    bit done;
    done = 0;
    cap_idx.delete(); cap_hit.delete(); cap_last.delete();
    cap_num.delete(); cap_cyc.delete();
    cap_timeout   = 0;
    cap_rdy_after = 1'bx;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk);
      #1;
      if (bus.match_valid) begin
        cap_idx.push_back(int'(bus.match_index));
        cap_hit.push_back(bus.match_hit);
        cap_last.push_back(bus.match_last);
        cap_num.push_back(int'(bus.match_num));
        cap_cyc.push_back(cyc - t_acc);
        if (bus.match_last) done = 1;
      end
    end
    if (!done) cap_timeout = 1;
    else begin
      @(posedge clk);
      #1;
      cap_rdy_after = bus.bv_ready;
    end
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    bus.bv_valid    = 1'b0;
    bus.bv          = '0;
    bus.match_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.bv_ready !== 1'b1 || bus.match_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: bv_ready=%b match_valid=%b, want 1/0", bus.bv_ready, bus.match_valid);
    end
    total++;
    if (bus.match_index !== 6'd0 || bus.match_hit !== 1'b0 || bus.match_last !== 1'b0 || bus.match_num !== 7'd0) begin
      bad++;
      $display("FAIL reset_out: idx=%0d hit=%b last=%b num=%0d, want all 0",
               bus.match_index, bus.match_hit, bus.match_last, bus.match_num);
    end
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_lsb();
    send_vec(64'h1);
    collect();
    total++;
    if (cap_timeout || cap_idx.size() != 1) begin
      bad++;
      $display("FAIL lsb_count: beats=%0d timeout=%b, want 1 beat", cap_idx.size(), cap_timeout);
    end else begin
      total++;
      if (cap_idx[0] != 0 || cap_hit[0] !== 1'b1 || cap_last[0] !== 1'b1 || cap_num[0] != 1 || cap_cyc[0] != 1) begin
        bad++;
        $display("FAIL lsb_beat: idx=%0d hit=%b last=%b num=%0d cyc=%0d, want 0/1/1/1/1",
                 cap_idx[0], cap_hit[0], cap_last[0], cap_num[0], cap_cyc[0]);
      end
      total++;
      if (cap_rdy_after !== 1'b1) begin
        bad++;
        $display("FAIL lsb_ready_after: bv_ready=%b, want 1", cap_rdy_after);
      end
    end
  endtask

  task automatic test_msb_skip();
    send_vec(64'h8000_0000_0000_0000);
    collect();
    total++;
    if (cap_timeout || cap_idx.size() != 1) begin
      bad++;
      $display("FAIL msb_count: beats=%0d timeout=%b, want 1 beat", cap_idx.size(), cap_timeout);
    end else begin
      total++;
      if (cap_idx[0] != 63 || cap_hit[0] !== 1'b1 || cap_last[0] !== 1'b1 || cap_num[0] != 1 || cap_cyc[0] != 8) begin
        bad++;
        $display("FAIL msb_beat: idx=%0d hit=%b last=%b num=%0d cyc=%0d, want 63/1/1/1/8",
                 cap_idx[0], cap_hit[0], cap_last[0], cap_num[0], cap_cyc[0]);
      end
    end
  endtask

  task automatic test_multi();
    int exp_idx[4] = '{0, 2, 8, 63};
    int exp_cyc[4] = '{1, 3, 6, 14};
    send_vec(64'h8000_0000_0000_0105);
    collect();
    total++;
    if (cap_timeout || cap_idx.size() != 4) begin
      bad++;
      $display("FAIL multi_count: beats=%0d timeout=%b, want 4", cap_idx.size(), cap_timeout);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cap_idx[i] != exp_idx[i] || cap_hit[i] !== 1'b1 || cap_last[i] !== (i == 3) ||
            cap_num[i] != i + 1 || cap_cyc[i] != exp_cyc[i]) begin
          bad++;
          $display("FAIL multi_beat%0d: idx=%0d hit=%b last=%b num=%0d cyc=%0d, want %0d/1/%0d/%0d/%0d",
                   i, cap_idx[i], cap_hit[i], cap_last[i], cap_num[i], cap_cyc[i],
                   exp_idx[i], (i == 3), i + 1, exp_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_zero();
    send_vec(64'h0);
    collect();
    total++;
    if (cap_timeout || cap_idx.size() != 1) begin
      bad++;
      $display("FAIL zero_count: beats=%0d timeout=%b, want 1", cap_idx.size(), cap_timeout);
    end else begin
      total++;
      if (cap_idx[0] != 0 || cap_hit[0] !== 1'b0 || cap_last[0] !== 1'b1 || cap_num[0] != 0 || cap_cyc[0] != 1) begin
        bad++;
        $display("FAIL zero_beat: idx=%0d hit=%b last=%b num=%0d cyc=%0d, want 0/0/1/0/1",
                 cap_idx[0], cap_hit[0], cap_last[0], cap_num[0], cap_cyc[0]);
      end
    end
  endtask

  task automatic test_stall();
    bit seen;
    seen = 0;
    bus.match_ready = 1'b0;
    send_vec(64'h3);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.match_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL stall_first: no beat within bound, want beat");
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.bv       = 64'hFF00;
        bus.bv_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.bv_valid = 1'b0;
      bus.bv       = '0;
      total++;
      if (bus.match_valid !== 1'b1 || bus.match_index !== 6'd0 || bus.bv_ready !== 1'b0 ||
          bus.match_last !== 1'b0 || bus.match_num !== 7'd1) begin
        bad++;
        $display("FAIL stall_hold%0d: valid=%b idx=%0d bv_ready=%b last=%b num=%0d, want 1/0/0/0/1",
                 c, bus.match_valid, bus.match_index, bus.bv_ready, bus.match_last, bus.match_num);
      end
    end
    bus.match_ready = 1'b1;
    t_acc = cyc;
    collect();
    total++;
    if (cap_timeout || cap_idx.size() != 1) begin
      bad++;
      $display("FAIL stall_count: beats=%0d timeout=%b, want 1", cap_idx.size(), cap_timeout);
    end else begin
      total++;
      if (cap_idx[0] != 1 || cap_last[0] !== 1'b1 || cap_num[0] != 2 || cap_cyc[0] != 2) begin
        bad++;
        $display("FAIL stall_second: idx=%0d last=%b num=%0d cyc=%0d, want 1/1/2/2",
                 cap_idx[0], cap_last[0], cap_num[0], cap_cyc[0]);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus.match_valid !== 1'b0 || bus.bv_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_no_capture: valid=%b bv_ready=%b, want 0/1", bus.match_valid, bus.bv_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    bus.match_ready = 1'b0;
    send_vec(64'hF0);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.match_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rstmid_emit: no beat within bound");
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (bus.match_valid !== 1'b0 || bus.bv_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_async: valid=%b bv_ready=%b, want 0/1", bus.match_valid, bus.bv_ready);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    bus.match_ready = 1'b1;
    @(posedge clk);
    #1;
    send_vec(64'h4);
    collect();
    total++;
    if (cap_timeout || cap_idx.size() != 1) begin
      bad++;
      $display("FAIL rstmid_count: beats=%0d timeout=%b, want 1", cap_idx.size(), cap_timeout);
    end else begin
      total++;
      if (cap_idx[0] != 2 || cap_hit[0] !== 1'b1 || cap_last[0] !== 1'b1 || cap_num[0] != 1 || cap_cyc[0] != 1) begin
        bad++;
        $display("FAIL rstmid_beat: idx=%0d hit=%b last=%b num=%0d cyc=%0d, want 2/1/1/1/1",
                 cap_idx[0], cap_hit[0], cap_last[0], cap_num[0], cap_cyc[0]);
      end
    end
  endtask

  // Model: expected beats are the set-bit positions in ascending order; the next
  // beat appears 2 cycles after the previous plus one per chunk boundary crossed.
  task automatic test_random();
    logic [63:0] v;
    int exp_idx[$];
    int exp_cyc[$];
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: v = 64'h0;
        1: begin v = 64'h1; v = v << $urandom_range(0, 63); end
        2: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        3: v = {$urandom, $urandom};
        default: begin
          v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
          v = v & (64'hFF << (8 * $urandom_range(0, 7)));
        end
      endcase
      exp_idx.delete();
      exp_cyc.delete();
      for (int i = 0; i < 64; i++) if (v[i]) exp_idx.push_back(i);
      if (exp_idx.size() == 0) exp_cyc.push_back(1);
      else begin
        exp_cyc.push_back(1 + exp_idx[0] / 8);
        for (int i = 1; i < exp_idx.size(); i++)
          exp_cyc.push_back(exp_cyc[i-1] + 2 + (exp_idx[i] / 8 - exp_idx[i-1] / 8));
      end
      send_vec(v);
      collect();
      total++;
      if (cap_timeout || cap_idx.size() != exp_cyc.size() || cap_rdy_after !== 1'b1) begin
        bad++;
        $display("FAIL rand_count v=%h: beats=%0d timeout=%b ready_after=%b, want %0d/0/1",
                 v, cap_idx.size(), cap_timeout, cap_rdy_after, exp_cyc.size());
        continue;
      end
      for (int i = 0; i < cap_idx.size(); i++) begin
        int  e_idx;
        int  e_num;
        bit  e_hit;
        e_hit = (exp_idx.size() != 0);
        e_idx = e_hit ? exp_idx[i] : 0;
        e_num = e_hit ? i + 1 : 0;
        total++;
        if (cap_idx[i] != e_idx || cap_hit[i] !== e_hit || cap_last[i] !== (i == cap_idx.size() - 1) ||
            cap_num[i] != e_num || cap_cyc[i] != exp_cyc[i]) begin
          bad++;
          $display("FAIL rand_beat v=%h #%0d: idx=%0d hit=%b last=%b num=%0d cyc=%0d, want %0d/%b/%0d/%0d/%0d",
                   v, i, cap_idx[i], cap_hit[i], cap_last[i], cap_num[i], cap_cyc[i],
                   e_idx, e_hit, (i == cap_idx.size() - 1), e_num, exp_cyc[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_lsb();
    test_msb_skip();
    test_multi();
    test_zero();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
